opc_intc: RTL
=============

OPC_INTC -- requirements
Module: opc_intc

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, meaning number of interrupt channels, legal range 1..16.
REQ-002 SHALL have parameter VECTOR_BASE, default 20'h2, meaning the vector issued for channel 0.
REQ-003 SHALL have parameter VECTOR_STRIDE, default 2, meaning the vector spacing between adjacent channels.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_b, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port clken, input, 1 bit: clock enable; no state changes when it is low.
REQ-007 SHALL have port irq_b, input, NUM_IRQ bits: asynchronous active-low interrupt sources.
REQ-008 SHALL have register-port inputs sel (1 bit), rnw (1 bit), addr (2 bits) and din (32 bits).
REQ-009 SHALL have register-port output dout, 32 bits.
REQ-010 SHALL have port int_b, output, 1 bit: active-low interrupt request to the CPU.
REQ-011 SHALL have port ack, input, 1 bit: one-cycle pulse when the CPU takes the interrupt.
REQ-012 SHALL have port eoi, input, 1 bit: one-cycle end-of-interrupt pulse.
REQ-013 SHALL have port vector, output, 20 bits: handler address for the last acknowledge.

Function
REQ-014 SHALL synchronise each irq_b bit through two flops, then detect falling edges (1 then 0).
REQ-015 SHALL set PENDING[i] on each detected falling edge of channel i.
REQ-016 SHALL implement registers at addr 0 PENDING (read; write-1-to-clear), 1 MASK (read/write; 1 = enabled), 2 INSERVICE (read-only), 3 VECTOR (read-only, zero-extended).
REQ-017 SHALL perform a register write when sel=1 and rnw=0; dout SHALL be combinational on addr when sel=1, and 0 otherwise.
REQ-018 SHALL give channel 0 the highest priority; the eligible set is PENDING & MASK, restricted to channels above the highest-priority INSERVICE bit.
REQ-019 SHALL implement FSM IDLE/REQ/SERVICE:
- IDLE->REQ when the eligible set is non-empty.
- REQ: int_b=0.
- REQ + ack -> SERVICE.
- SERVICE + eoi, with INSERVICE empty after the clear -> IDLE.
REQ-020 On ack, SHALL capture id = highest-priority eligible channel, clear PENDING[id], set INSERVICE[id], and set vector = VECTOR_BASE + id*VECTOR_STRIDE (20-bit wrap) in the same edge.
REQ-021 SHALL drive int_b high in IDLE and SERVICE, from the edge following ack.
REQ-022 On eoi, SHALL clear the highest-priority INSERVICE bit; eoi with INSERVICE empty SHALL be ignored.
REQ-023 When REQ sees ack with an empty eligible set (masked or cleared since the request), SHALL make it spurious: vector = VECTOR_BASE + NUM_IRQ*VECTOR_STRIDE, no INSERVICE change, return to IDLE if INSERVICE is empty, else SERVICE.
REQ-024 SHALL let a new edge win over a write-1-clear to the same PENDING bit in the same cycle.
REQ-025 SHALL, when eligibility vanishes while in REQ without ack, return to IDLE (or SERVICE) and deassert int_b the next cycle.
REQ-026 SHALL ignore an ack outside REQ.
REQ-027 SHALL process ack before eoi when both are high in the same cycle.
REQ-028 SHALL set int_b low no earlier than 4 clken cycles after the irq_b fall (2 sync, 1 edge/pending, 1 FSM).

Reset
REQ-029 While reset_b=0, SHALL force FSM=IDLE, PENDING=0, MASK=0, INSERVICE=0, vector=0, int_b=1, and sync flops=1, asynchronously, independent of clken.
REQ-030 SHALL discard any interrupt in flight on reset mid-operation; no edge SHALL be detected from the reset-release sync values.

Configuration
REQ-031 SHALL support macro OPC_INTC_NESTING_EN.
- Defined: SERVICE->REQ when a channel of higher priority than every INSERVICE bit becomes eligible, allowing nested INSERVICE bits.
- Undefined: SERVICE never enters REQ; at most one INSERVICE bit is set, and the eligible set ignores priority versus INSERVICE.

Verification
REQ-032 Reset, MASK=8'h04, irq_b[2] falls -> int_b=0 four cycles later; ack -> vector=20'h6, INSERVICE=8'h04, PENDING=0, int_b=1.
REQ-033 irq_b[5] and irq_b[1] fall together, MASK=8'hFF -> first ack gives vector=20'h4; after eoi, second ack gives vector=20'hC.
REQ-034 Request pending, MASK written 0 the same cycle as ack -> vector=20'h12 (spurious, NUM_IRQ=8), INSERVICE unchanged, FSM IDLE.
REQ-035 With OPC_INTC_NESTING_EN, channel 3 in service, irq_b[0] falls -> int_b=0, ack gives vector=20'h2, INSERVICE=8'h09; without the macro -> int_b stays 1 until eoi.
REQ-036 reset_b pulsed low during REQ -> int_b=1 immediately, all registers 0; no interrupt after release with irq_b held low.

Source files
------------

// File: rtl/opc_intc.sv
// opc_intc: prioritised interrupt controller with synchronised, edge-triggered active-low inputs.
// Define OPC_INTC_NESTING_EN to let a higher-priority channel preempt the one in service.
module opc_intc #(
  parameter int          NUM_IRQ       = 8,
  parameter logic [19:0] VECTOR_BASE   = 20'h2,
  parameter int          VECTOR_STRIDE = 2
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic               clken,
  input  logic [NUM_IRQ-1:0] irq_b,
  input  logic               sel,
  input  logic               rnw,
  input  logic [1:0]         addr,
  input  logic [31:0]        din,
  output logic [31:0]        dout,
  output logic               int_b,
  input  logic               ack,
  input  logic               eoi,
  output logic [19:0]        vector
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [1:0]         arm_q, arm_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d, mask_q, mask_d, inservice_q, inservice_d;
  logic [19:0]        vector_q, vector_d;

  logic [NUM_IRQ-1:0] fall, w1c, pend_c, above, eligible, ack_elig, ack_set, ins_a, eoi_clr;
  logic [4:0]         ack_id, eoi_id;
  logic               wr, take, hit;
  logic               unused_din;
`ifdef OPC_INTC_NESTING_EN
  logic [4:0]         top_ins;
`endif

  // Index of the lowest set bit, i.e. the highest-priority channel in v.
  function automatic logic [4:0] first_set(input logic [NUM_IRQ-1:0] v);
    first_set = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (v[i]) first_set = 5'(i);
  endfunction

  always_comb begin
    sync1_d = irq_b;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    arm_d   = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    // Until three edges have passed the chain still holds reset values, so no edge is trusted.
    fall    = (arm_q == 2'd3) ? (sync3_q & ~sync2_q) : '0;

    wr     = sel && !rnw;
    w1c    = (wr && addr == 2'd0) ? din[NUM_IRQ-1:0] : '0;
    mask_d = (wr && addr == 2'd1) ? din[NUM_IRQ-1:0] : mask_q;
    pend_c = pending_q & ~w1c;

`ifdef OPC_INTC_NESTING_EN
    top_ins = first_set(inservice_q);
    for (int i = 0; i < NUM_IRQ; i++)
      above[i] = (inservice_q == '0) || (5'(i) < top_ins);
`else
    above = '1;
`endif

    eligible = pending_q & mask_q & above;
    // The acknowledge sees this cycle's mask write and W1C, so a late mask makes it spurious.
    ack_elig = pend_c & mask_d & above;
    ack_id   = first_set(ack_elig);
    take     = (state_q == REQ) && ack;
    hit      = take && (ack_elig != '0);
    for (int i = 0; i < NUM_IRQ; i++)
      ack_set[i] = hit && (5'(i) == ack_id);

    ins_a  = inservice_q | ack_set;
    eoi_id = first_set(ins_a);
    for (int i = 0; i < NUM_IRQ; i++)
      eoi_clr[i] = eoi && ins_a[i] && (5'(i) == eoi_id);
    inservice_d = ins_a & ~eoi_clr;
    pending_d   = (pend_c & ~ack_set) | fall;

    vector_d = vector_q;
    if (hit)
      vector_d = VECTOR_BASE + 20'(ack_id) * 20'(VECTOR_STRIDE);
    else if (take)
      vector_d = VECTOR_BASE + 20'(NUM_IRQ) * 20'(VECTOR_STRIDE);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (eligible != '0) state_d = REQ;
      end
      REQ: begin
        if (take || eligible == '0)
          state_d = (inservice_d == '0) ? IDLE : SERVICE;
      end
      SERVICE: begin
        if (inservice_d == '0) state_d = IDLE;
`ifdef OPC_INTC_NESTING_EN
        else if (eligible != '0) state_d = REQ;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout = '0;
    if (sel) begin
      case (addr)
        2'd0:    dout = 32'(pending_q);
        2'd1:    dout = 32'(mask_q);
        2'd2:    dout = 32'(inservice_q);
        default: dout = 32'(vector_q);
      endcase
    end
  end

  assign int_b      = (state_q != REQ);
  assign vector     = vector_q;
  assign unused_din = ^din;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= IDLE;
      sync1_q     <= '1;
      sync2_q     <= '1;
      sync3_q     <= '1;
      arm_q       <= 2'd0;
      pending_q   <= '0;
      mask_q      <= '0;
      inservice_q <= '0;
      vector_q    <= '0;
    end else if (clken) begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      arm_q       <= arm_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      inservice_q <= inservice_d;
      vector_q    <= vector_d;
    end
  end
endmodule
